// File: rtl/fft_4_stream_ctrl.sv
// Streaming sequencer around an external combinational 4-point FFT core.
// Four input beats are gathered onto the core operand registers. After a
// programmable settle time, the four core results are snapshotted. The
// snapshot is then streamed out in natural order with valid/ready.
module fft_4_stream_ctrl #(
    parameter int DATA_WIDTH    = 64,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    // input sample stream
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_r,
    input  logic [DATA_WIDTH-1:0] s_i,
    // output sample stream
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_r,
    output logic [DATA_WIDTH-1:0] m_i,
    output logic                  m_last,
    output logic                  busy,
    // FFT core operands
    output logic [DATA_WIDTH-1:0] core_x1_r,
    output logic [DATA_WIDTH-1:0] core_x1_i,
    output logic [DATA_WIDTH-1:0] core_x2_r,
    output logic [DATA_WIDTH-1:0] core_x2_i,
    output logic [DATA_WIDTH-1:0] core_x3_r,
    output logic [DATA_WIDTH-1:0] core_x3_i,
    output logic [DATA_WIDTH-1:0] core_x4_r,
    output logic [DATA_WIDTH-1:0] core_x4_i,
    // FFT core results
    input  logic [DATA_WIDTH-1:0] core_y1_r,
    input  logic [DATA_WIDTH-1:0] core_y1_i,
    input  logic [DATA_WIDTH-1:0] core_y2_r,
    input  logic [DATA_WIDTH-1:0] core_y2_i,
    input  logic [DATA_WIDTH-1:0] core_y3_r,
    input  logic [DATA_WIDTH-1:0] core_y3_i,
    input  logic [DATA_WIDTH-1:0] core_y4_r,
    input  logic [DATA_WIDTH-1:0] core_y4_i
);

    localparam int                CNT_W       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_UNLOAD = 2'd2
    } state_t;

    state_t                  state;
    logic [1:0]              in_idx;
    logic [1:0]              out_idx;
    logic [CNT_W-1:0]        settle_cnt;

    logic [DATA_WIDTH-1:0]   x_r   [4];
    logic [DATA_WIDTH-1:0]   x_i   [4];
    logic [DATA_WIDTH-1:0]   buf_r [4];
    logic [DATA_WIDTH-1:0]   buf_i [4];
    logic [DATA_WIDTH-1:0]   y_r   [4];
    logic [DATA_WIDTH-1:0]   y_i   [4];

    // Operand registers drive the core directly; results are gathered into arrays.
    assign core_x1_r = x_r[0];
    assign core_x1_i = x_i[0];
    assign core_x2_r = x_r[1];
    assign core_x2_i = x_i[1];
    assign core_x3_r = x_r[2];
    assign core_x3_i = x_i[2];
    assign core_x4_r = x_r[3];
    assign core_x4_i = x_i[3];

    assign y_r[0] = core_y1_r;
    assign y_i[0] = core_y1_i;
    assign y_r[1] = core_y2_r;
    assign y_i[1] = core_y2_i;
    assign y_r[2] = core_y3_r;
    assign y_i[2] = core_y3_i;
    assign y_r[3] = core_y4_r;
    assign y_i[3] = core_y4_i;

    // Input is accepted only in LOAD, and never while reset is asserted.
    assign s_ready = (state == ST_LOAD) && !rst;

    // Output beat is selected from the snapshot buffer by the unload index.
    assign m_r    = buf_r[out_idx];
    assign m_i    = buf_i[out_idx];
    assign m_last = m_valid && (out_idx == 2'd3);

    // Frame sequencer: load four operands, settle, snapshot results, unload four beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LOAD;
            in_idx     <= 2'd0;
            out_idx    <= 2'd0;
            settle_cnt <= '0;
            m_valid    <= 1'b0;
            busy       <= 1'b0;
            // NOTE: the operand and snapshot arrays are cleared on reset on
            // purpose, so the core sees zeros and m_r/m_i read 0 after reset;
            // this costs a reset net on every bit of these registers.
            for (int k = 0; k < 4; k++) begin
                x_r[k]   <= '0;
                x_i[k]   <= '0;
                buf_r[k] <= '0;
                buf_i[k] <= '0;
            end
        end else begin
            // NOTE: every register here uses <= so all updates take effect
            // together at the clock edge regardless of statement order.
            case (state)
                ST_LOAD: begin
                    if (s_valid) begin
                        x_r[in_idx] <= s_r;
                        x_i[in_idx] <= s_i;
                        if (in_idx == 2'd3) begin
                            in_idx     <= 2'd0;
                            settle_cnt <= '0;
                            busy       <= 1'b1;
                            state      <= ST_SETTLE;
                        end else begin
                            in_idx <= in_idx + 2'd1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        for (int k = 0; k < 4; k++) begin
                            buf_r[k] <= y_r[k];
                            buf_i[k] <= y_i[k];
                        end
                        m_valid <= 1'b1;
                        state   <= ST_UNLOAD;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_UNLOAD: begin
                    if (m_ready) begin
                        if (out_idx == 2'd3) begin
                            out_idx <= 2'd0;
                            m_valid <= 1'b0;
                            busy    <= 1'b0;
                            state   <= ST_LOAD;
                        end else begin
                            out_idx <= out_idx + 2'd1;
                        end
                    end
                end
                default: begin
                    state   <= ST_LOAD;
                    m_valid <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_4_stream_ctrl.sv
// Directed bench for fft_4_stream_ctrl. The FFT core is stubbed as a
// reversal (y_k = x_{5-k}). A second instance with SETTLE_CYCLES=3 has a stub
// that is deliberately wrong for the first two settle cycles.
module tb_fft_4_stream_ctrl;

    localparam int DW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // instance with SETTLE_CYCLES = 1
    logic          s_valid, s_ready, m_valid, m_ready, m_last, busy;
    logic [DW-1:0] s_r, s_i, m_r, m_i;
    logic [DW-1:0] cx_r [4];
    logic [DW-1:0] cx_i [4];
    logic [DW-1:0] cy_r [4];
    logic [DW-1:0] cy_i [4];

    // instance with SETTLE_CYCLES = 3
    logic          s_valid3, s_ready3, m_valid3, m_ready3, m_last3, busy3;
    logic [DW-1:0] s_r3, s_i3, m_r3, m_i3;
    logic [DW-1:0] cx3_r [4];
    logic [DW-1:0] cx3_i [4];
    logic [DW-1:0] cy3_r [4];
    logic [DW-1:0] cy3_i [4];
    logic [DW-1:0] stub_off;

    // Core stubs: reversal, plus a settle-time disturbance on the second instance.
    for (genvar k = 0; k < 4; k++) begin : g_stub
        assign cy_r[k]  = cx_r[3-k];
        assign cy_i[k]  = cx_i[3-k];
        assign cy3_r[k] = cx3_r[3-k] + stub_off;
        assign cy3_i[k] = cx3_i[3-k] + stub_off;
    end

    fft_4_stream_ctrl #(.DATA_WIDTH(DW), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_r(s_r), .s_i(s_i),
        .m_valid(m_valid), .m_ready(m_ready), .m_r(m_r), .m_i(m_i),
        .m_last(m_last), .busy(busy),
        .core_x1_r(cx_r[0]), .core_x1_i(cx_i[0]),
        .core_x2_r(cx_r[1]), .core_x2_i(cx_i[1]),
        .core_x3_r(cx_r[2]), .core_x3_i(cx_i[2]),
        .core_x4_r(cx_r[3]), .core_x4_i(cx_i[3]),
        .core_y1_r(cy_r[0]), .core_y1_i(cy_i[0]),
        .core_y2_r(cy_r[1]), .core_y2_i(cy_i[1]),
        .core_y3_r(cy_r[2]), .core_y3_i(cy_i[2]),
        .core_y4_r(cy_r[3]), .core_y4_i(cy_i[3])
    );

    fft_4_stream_ctrl #(.DATA_WIDTH(DW), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid3), .s_ready(s_ready3), .s_r(s_r3), .s_i(s_i3),
        .m_valid(m_valid3), .m_ready(m_ready3), .m_r(m_r3), .m_i(m_i3),
        .m_last(m_last3), .busy(busy3),
        .core_x1_r(cx3_r[0]), .core_x1_i(cx3_i[0]),
        .core_x2_r(cx3_r[1]), .core_x2_i(cx3_i[1]),
        .core_x3_r(cx3_r[2]), .core_x3_i(cx3_i[2]),
        .core_x4_r(cx3_r[3]), .core_x4_i(cx3_i[3]),
        .core_y1_r(cy3_r[0]), .core_y1_i(cy3_i[0]),
        .core_y2_r(cy3_r[1]), .core_y2_i(cy3_i[1]),
        .core_y3_r(cy3_r[2]), .core_y3_i(cy3_i[2]),
        .core_y4_r(cy3_r[3]), .core_y4_i(cy3_i[3])
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Log of output handshakes on the first instance (ignoring reset cycles).
    int            hs_cnt = 0;
    logic [DW-1:0] hs_log [64];

    always @(posedge clk) begin
        if (m_valid && m_ready && !rst) begin
            if (hs_cnt < 64) hs_log[hs_cnt] = m_r;
            hs_cnt = hs_cnt + 1;
        end
    end

    function automatic logic [DW-1:0] neg(input int k);
        return 64'(-k);
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one beat on the first instance at a falling edge.
    task automatic send_beat(input int r, input int i);
        @(negedge clk);
        check("load_s_ready", {63'd0, s_ready}, 64'd1);
        s_valid = 1'b1;
        s_r     = 64'(r);
        s_i     = neg(-i);
    endtask

    // Observe one output beat on the first instance (m_ready left as is).
    task automatic expect_out(input string tag, input int r, input int i, input logic last);
        @(negedge clk);
        check({tag, "_valid"}, {63'd0, m_valid}, 64'd1);
        check({tag, "_r"}, m_r, 64'(r));
        check({tag, "_i"}, m_i, neg(-i));
        check({tag, "_last"}, {63'd0, m_last}, {63'd0, last});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1; s_valid = 1'b1; s_r = 64'd99; s_i = 64'd99; m_ready = 1'b1;
        s_valid3 = 1'b0; s_r3 = '0; s_i3 = '0; m_ready3 = 1'b1; stub_off = '0;

        // 1: reset held three cycles with s_valid high
        repeat (3) begin
            @(negedge clk);
            check("rst_s_ready", {63'd0, s_ready}, 64'd0);
            check("rst_m_valid", {63'd0, m_valid}, 64'd0);
            check("rst_m_r", m_r, 64'd0);
            check("rst_m_last", {63'd0, m_last}, 64'd0);
            check("rst_busy", {63'd0, busy}, 64'd0);
            check("rst_x1_r", cx_r[0], 64'd0);
            check("rst_x4_i", cx_i[3], 64'd0);
            check("rst_s_ready3", {63'd0, s_ready3}, 64'd0);
        end
        rst = 1'b0; s_valid = 1'b0;
        #1;
        check("rel_s_ready", {63'd0, s_ready}, 64'd1);

        // 2: single frame, back-to-back input
        send_beat(1, -1); send_beat(2, -2); send_beat(3, -3); send_beat(4, -4);
        @(negedge clk);            // T+1
        s_valid = 1'b0;
        check("t2_settle_m_valid", {63'd0, m_valid}, 64'd0);
        check("t2_settle_busy", {63'd0, busy}, 64'd1);
        check("t2_settle_s_ready", {63'd0, s_ready}, 64'd0);
        check("t2_x1_r", cx_r[0], 64'd1);
        check("t2_x4_i", cx_i[3], neg(4));
        expect_out("t2_y1", 4, -4, 1'b0);
        expect_out("t2_y2", 3, -3, 1'b0);
        expect_out("t2_y3", 2, -2, 1'b0);
        expect_out("t2_y4", 1, -1, 1'b1);
        @(negedge clk);
        check("t2_done_m_valid", {63'd0, m_valid}, 64'd0);
        check("t2_done_s_ready", {63'd0, s_ready}, 64'd1);
        check("t2_done_busy", {63'd0, busy}, 64'd0);

        // 3: backpressure while beat 2 is presented
        base = hs_cnt;
        send_beat(1, -1); send_beat(2, -2); send_beat(3, -3); send_beat(4, -4);
        @(negedge clk);
        s_valid = 1'b0;
        expect_out("t3_y1", 4, -4, 1'b0);
        @(negedge clk);
        check("t3_y2_first", m_r, 64'd3);
        m_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("t3_hold_valid", {63'd0, m_valid}, 64'd1);
            check("t3_hold_r", m_r, 64'd3);
            check("t3_hold_i", m_i, neg(3));
            check("t3_hold_last", {63'd0, m_last}, 64'd0);
        end
        m_ready = 1'b1;
        expect_out("t3_y3", 2, -2, 1'b0);
        expect_out("t3_y4", 1, -1, 1'b1);
        @(negedge clk);
        check("t3_done_m_valid", {63'd0, m_valid}, 64'd0);
        check("t3_hs_count", 64'(hs_cnt - base), 64'd4);
        check("t3_hs0", hs_log[base],   64'd4);
        check("t3_hs1", hs_log[base+1], 64'd3);
        check("t3_hs2", hs_log[base+2], 64'd2);
        check("t3_hs3", hs_log[base+3], 64'd1);

        // 4: gapped input, then s_valid held high through SETTLE/UNLOAD
        for (int k = 0; k < 4; k++) begin
            send_beat(5 + k, -(5 + k));
            @(negedge clk);
            s_valid = 1'b0;
            if (k == 0) begin
                check("t4_x1_new", cx_r[0], 64'd5);
                check("t4_x2_kept", cx_r[1], 64'd2);
            end
        end
        // now at T+1
        s_valid = 1'b1; s_r = 64'd77; s_i = 64'd77;
        check("t4_settle_s_ready", {63'd0, s_ready}, 64'd0);
        expect_out("t4_y1", 8, -8, 1'b0);
        check("t4_unload_s_ready", {63'd0, s_ready}, 64'd0);
        check("t4_unload_x1", cx_r[0], 64'd5);
        expect_out("t4_y2", 7, -7, 1'b0);
        expect_out("t4_y3", 6, -6, 1'b0);
        expect_out("t4_y4", 5, -5, 1'b1);
        s_valid = 1'b0;
        @(negedge clk);
        check("t4_done_s_ready", {63'd0, s_ready}, 64'd1);
        check("t4_done_x1", cx_r[0], 64'd5);
        check("t4_done_x4", cx_r[3], 64'd8);
        check("t4_done_m_valid", {63'd0, m_valid}, 64'd0);

        // 5: reset after two outputs of a frame, then a fresh frame
        send_beat(1, -1); send_beat(2, -2); send_beat(3, -3); send_beat(4, -4);
        @(negedge clk);
        s_valid = 1'b0;
        expect_out("t5_y1", 4, -4, 1'b0);
        expect_out("t5_y2", 3, -3, 1'b0);
        @(negedge clk);
        check("t5_pre_rst_r", m_r, 64'd2);
        rst = 1'b1;
        #1;
        check("t5_rst_s_ready", {63'd0, s_ready}, 64'd0);
        @(negedge clk);
        check("t5_rst_m_valid", {63'd0, m_valid}, 64'd0);
        check("t5_rst_busy", {63'd0, busy}, 64'd0);
        check("t5_rst_x1", cx_r[0], 64'd0);
        rst = 1'b0;
        base = hs_cnt;
        send_beat(10, -10); send_beat(20, -20); send_beat(30, -30); send_beat(40, -40);
        @(negedge clk);
        s_valid = 1'b0;
        check("t5_x1", cx_r[0], 64'd10);
        check("t5_x4", cx_r[3], 64'd40);
        expect_out("t5_z1", 40, -40, 1'b0);
        expect_out("t5_z2", 30, -30, 1'b0);
        expect_out("t5_z3", 20, -20, 1'b0);
        expect_out("t5_z4", 10, -10, 1'b1);
        repeat (4) @(negedge clk);
        check("t5_hs_count", 64'(hs_cnt - base), 64'd4);
        check("t5_hs0", hs_log[base],   64'd40);
        check("t5_hs1", hs_log[base+1], 64'd30);
        check("t5_hs2", hs_log[base+2], 64'd20);
        check("t5_hs3", hs_log[base+3], 64'd10);

        // 6: SETTLE_CYCLES = 3 with a core stub that is wrong until T+3
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("t6_s_ready", {63'd0, s_ready3}, 64'd1);
            s_valid3 = 1'b1;
            s_r3     = 64'(k);
            s_i3     = neg(k);
        end
        @(negedge clk);            // T+1
        s_valid3 = 1'b0; stub_off = 64'd111;
        check("t6_T1_m_valid", {63'd0, m_valid3}, 64'd0);
        @(negedge clk);            // T+2
        stub_off = 64'd222;
        check("t6_T2_m_valid", {63'd0, m_valid3}, 64'd0);
        @(negedge clk);            // T+3
        stub_off = 64'd0;
        check("t6_T3_m_valid", {63'd0, m_valid3}, 64'd0);
        check("t6_T3_busy", {63'd0, busy3}, 64'd1);
        @(negedge clk);            // T+4
        stub_off = 64'd333;
        check("t6_T4_m_valid", {63'd0, m_valid3}, 64'd1);
        check("t6_y1_r", m_r3, 64'd4);
        check("t6_y1_i", m_i3, neg(4));
        check("t6_y1_last", {63'd0, m_last3}, 64'd0);
        @(negedge clk);
        check("t6_y2_r", m_r3, 64'd3);
        @(negedge clk);
        check("t6_y3_r", m_r3, 64'd2);
        @(negedge clk);
        check("t6_y4_r", m_r3, 64'd1);
        check("t6_y4_i", m_i3, neg(1));
        check("t6_y4_last", {63'd0, m_last3}, 64'd1);
        @(negedge clk);
        check("t6_done_m_valid", {63'd0, m_valid3}, 64'd0);
        check("t6_done_s_ready", {63'd0, s_ready3}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
